multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore-style control FSM for a multi-cycle MIPS-like datapath. It walks each
// instruction through fetch, decode and the per-class execute/memory/writeback
// states. A wait counter guards the three states that wait on mem_ready. When
// the counter runs out, or DECODE sees an unknown opcode, the FSM parks in
// FAULT. It stays there until rst is asserted.
//
// Build option:
//   MC_BNE_EN  - when defined, opcode 000101 (bne) is decoded into BRANCH with
//                branch_ne=1. When undefined, that opcode is illegal and
//                branch_ne is tied low.
//
// Parameters:
//   TIMEOUT_CYC - maximum cycles a memory state waits for mem_ready (0 = off)
//   ST_W        - width of the state output, must be at least 4
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   op_code    in   6-bit instruction opcode, sampled in DECODE
//   mem_ready  in   completion strobe for the outstanding mem_req
//   mem_req, mem_write, i_or_d, ir_write, pc_write, branch, branch_ne,
//   mem_reg, reg_dest, reg_write, ALU_SRC_A
//              out  1-bit datapath controls
//   ALU_SRC_B, ALU_OP, pc_src
//              out  2-bit datapath controls
//   fault      out  sticky fault flag
//   fault_code out  01 illegal opcode, 10 memory timeout, 00 while no fault
//   state      out  current state encoding, zero-extended to ST_W bits
//
// State table:
//   IDLE   (0)  | post-reset, no memory request outstanding
//   FETCH  (1)  | instruction read, IR/PC load on mem_ready
//   DECODE (2)  | register read, branch target add, opcode latch
//   MEMADR (3)  | effective address for lw/sw
//   MEMRD  (4)  | data read, waits for mem_ready
//   MEMWB  (5)  | load data written to register file
//   MEMWR  (6)  | data write, waits for mem_ready
//   RTEXE  (7)  | R-type ALU operation
//   ALUWB  (8)  | R-type result written back
//   BRANCH (9)  | beq (or bne) compare and conditional PC update
//   ADDIEX (10) | addi ALU operation
//   ADDIWB (11) | addi result written back
//   JUMP   (12) | unconditional PC load
//   FAULT  (13) | parked until reset, controls off
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int TIMEOUT_CYC = 15,
    parameter int ST_W        = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      op_code,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_write,
    output logic            i_or_d,
    output logic            ir_write,
    output logic            pc_write,
    output logic            branch,
    output logic            branch_ne,
    output logic            mem_reg,
    output logic            reg_dest,
    output logic            reg_write,
    output logic            ALU_SRC_A,
    output logic [1:0]      ALU_SRC_B,
    output logic [1:0]      ALU_OP,
    output logic [1:0]      pc_src,
    output logic            fault,
    output logic [1:0]      fault_code,
    output logic [ST_W-1:0] state
);

    if (ST_W < 4) begin : g_st_w_check
        $error("multicycle_controller: ST_W must be at least 4");
    end

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? (($clog2(TIMEOUT_CYC + 1) > 0) ? $clog2(TIMEOUT_CYC + 1) : 1) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        RTEXE  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        JUMP   = 4'd12,
        FAULT  = 4'd13
    } state_t;

    // Registered control word. ir_write and pc_write are not stored directly:
    // in FETCH they have to follow mem_ready in the same cycle, so only the
    // "in FETCH" and "in JUMP" qualifiers are registered.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       i_or_d;
        logic       in_fetch;
        logic       pc_write_jump;
        logic       branch;
        logic       branch_ne;
        logic       mem_reg;
        logic       reg_dest;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       fault;
    } ctrl_t;

    state_t           state_q;
    state_t           state_d;
    logic [5:0]       op_q;
    logic [5:0]       op_d;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       code_d;
    logic             timeout;
    logic             bne_sel;
    ctrl_t            ctrl_q;
    ctrl_t            ctrl_d;

    // mem_ready is checked before the timeout, so a completion that lands on
    // the last allowed cycle still counts as completion.
    assign timeout = TMO_EN && !mem_ready && (wait_cnt == TMO_LAST);

    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        code_d  = FC_NONE;
        case (state_q)
            IDLE:   state_d = FETCH;
            FETCH: begin
                if (mem_ready) begin
                    state_d = DECODE;
                end else if (timeout) begin
                    state_d = FAULT;
                    code_d  = FC_TIMEOUT;
                end
            end
            DECODE: begin
                op_d = op_code;
                case (op_code)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTEXE;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = BRANCH;
`endif
                    default: begin
                        state_d = FAULT;
                        code_d  = FC_ILLEGAL;
                    end
                endcase
            end
            MEMADR: state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                if (mem_ready) begin
                    state_d = MEMWB;
                end else if (timeout) begin
                    state_d = FAULT;
                    code_d  = FC_TIMEOUT;
                end
            end
            MEMWR: begin
                if (mem_ready) begin
                    state_d = FETCH;
                end else if (timeout) begin
                    state_d = FAULT;
                    code_d  = FC_TIMEOUT;
                end
            end
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_d = FETCH;
            RTEXE:  state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            FAULT:  state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

`ifdef MC_BNE_EN
    assign bne_sel = (op_d == OP_BNE);
`else
    assign bne_sel = 1'b0;
`endif

    // Control word for the state being entered, so outputs come straight
    // from flops once the edge has happened.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            FETCH: begin
                ctrl_d.mem_req   = 1'b1;
                ctrl_d.in_fetch  = 1'b1;
                ctrl_d.alu_src_b = 2'b01;
            end
            DECODE: ctrl_d.alu_src_b = 2'b11;
            MEMADR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
            end
            MEMRD: begin
                ctrl_d.mem_req = 1'b1;
                ctrl_d.i_or_d  = 1'b1;
            end
            MEMWB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.mem_reg   = 1'b1;
            end
            MEMWR: begin
                ctrl_d.mem_req   = 1'b1;
                ctrl_d.mem_write = 1'b1;
                ctrl_d.i_or_d    = 1'b1;
            end
            RTEXE: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = 2'b10;
            end
            ALUWB: begin
                ctrl_d.reg_dest  = 1'b1;
                ctrl_d.reg_write = 1'b1;
            end
            BRANCH: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = 2'b01;
                ctrl_d.pc_src    = 2'b01;
                ctrl_d.branch    = !bne_sel;
                ctrl_d.branch_ne = bne_sel;
            end
            ADDIEX: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
            end
            ADDIWB: ctrl_d.reg_write = 1'b1;
            JUMP: begin
                ctrl_d.pc_write_jump = 1'b1;
                ctrl_d.pc_src        = 2'b10;
            end
            FAULT:  ctrl_d.fault = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            wait_cnt   <= '0;
            ctrl_q     <= '0;
            fault_code <= FC_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
            // Once in FAULT the code is frozen; elsewhere it is only non-zero
            // on the edge that enters FAULT.
            if (state_q != FAULT) begin
                fault_code <= code_d;
            end
            if ((state_d != state_q) && is_wait_state(state_d)) begin
                wait_cnt <= '0;
            end else if (is_wait_state(state_q) && !mem_ready && (wait_cnt != CNT_MAX)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_req   = ctrl_q.mem_req;
    assign mem_write = ctrl_q.mem_write;
    assign i_or_d    = ctrl_q.i_or_d;
    assign ir_write  = ctrl_q.in_fetch & mem_ready;
    assign pc_write  = ctrl_q.pc_write_jump | (ctrl_q.in_fetch & mem_ready);
    assign branch    = ctrl_q.branch;
    assign branch_ne = ctrl_q.branch_ne;
    assign mem_reg   = ctrl_q.mem_reg;
    assign reg_dest  = ctrl_q.reg_dest;
    assign reg_write = ctrl_q.reg_write;
    assign ALU_SRC_A = ctrl_q.alu_src_a;
    assign ALU_SRC_B = ctrl_q.alu_src_b;
    assign ALU_OP    = ctrl_q.alu_op;
    assign pc_src    = ctrl_q.pc_src;
    assign fault     = ctrl_q.fault;
    assign state     = ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed vector table covering reset, lw/sw/R/addi/beq/j/bne flows, the
// memory timeout and its completion-on-last-cycle boundary, and illegal
// opcodes. After that comes a randomized run checked against an
// instruction-route reference model. The DUT is built with TIMEOUT_CYC=4.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_controller;

    localparam int TMO = 4;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4,
                   S_MEMWB = 5, S_MEMWR = 6, S_RTEXE = 7, S_ALUWB = 8, S_BRANCH = 9,
                   S_ADDIEX = 10, S_ADDIWB = 11, S_JUMP = 12, S_FAULT = 13;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                           OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                           OP_SW = 6'b101011, OP_ILL = 6'b111111;

    // bit positions in the packed output word
    localparam int B_MREQ = 19, B_MWR = 18, B_IORD = 17, B_IRW = 16, B_PCW = 15,
                   B_BR = 14, B_BNE = 13, B_MREG = 12, B_RDST = 11, B_RWR = 10,
                   B_ASA = 9, B_FLT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op_code;
    logic       mem_ready;
    logic       mem_req, mem_write, i_or_d, ir_write, pc_write, branch, branch_ne;
    logic       mem_reg, reg_dest, reg_write, ALU_SRC_A, fault;
    logic [1:0] ALU_SRC_B, ALU_OP, pc_src, fault_code;
    logic [3:0] state;
    logic [19:0] act_out;

    multicycle_controller #(.TIMEOUT_CYC(TMO), .ST_W(4)) dut (
        .clk(clk), .rst(rst), .op_code(op_code), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
        .branch_ne(branch_ne), .mem_reg(mem_reg), .reg_dest(reg_dest),
        .reg_write(reg_write), .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B),
        .ALU_OP(ALU_OP), .pc_src(pc_src), .fault(fault),
        .fault_code(fault_code), .state(state)
    );

    always #5 clk = ~clk;

    assign act_out = {mem_req, mem_write, i_or_d, ir_write, pc_write, branch, branch_ne,
                      mem_reg, reg_dest, reg_write, ALU_SRC_A, ALU_SRC_B, ALU_OP, pc_src,
                      fault, fault_code};

    int n_cmp = 0;
    int n_bad = 0;

    // Expected output word for a state, straight from the per-state output list.
    function automatic logic [19:0] exp_out(input int s, input bit mr, input bit bne,
                                            input logic [1:0] fc);
        logic [19:0] o;
        o = '0;
        case (s)
            S_FETCH:  begin o[B_MREQ] = 1'b1; o[B_IRW] = mr; o[B_PCW] = mr; o[8:7] = 2'b01; end
            S_DECODE: o[8:7] = 2'b11;
            S_MEMADR: begin o[B_ASA] = 1'b1; o[8:7] = 2'b10; end
            S_MEMRD:  begin o[B_MREQ] = 1'b1; o[B_IORD] = 1'b1; end
            S_MEMWB:  begin o[B_RWR] = 1'b1; o[B_MREG] = 1'b1; end
            S_MEMWR:  begin o[B_MREQ] = 1'b1; o[B_MWR] = 1'b1; o[B_IORD] = 1'b1; end
            S_RTEXE:  begin o[B_ASA] = 1'b1; o[6:5] = 2'b10; end
            S_ALUWB:  begin o[B_RDST] = 1'b1; o[B_RWR] = 1'b1; end
            S_BRANCH: begin
                o[B_ASA] = 1'b1; o[6:5] = 2'b01; o[4:3] = 2'b01;
                o[B_BR] = !bne; o[B_BNE] = bne;
            end
            S_ADDIEX: begin o[B_ASA] = 1'b1; o[8:7] = 2'b10; end
            S_ADDIWB: o[B_RWR] = 1'b1;
            S_JUMP:   begin o[B_PCW] = 1'b1; o[4:3] = 2'b10; end
            S_FAULT:  begin o[B_FLT] = 1'b1; o[1:0] = fc; end
            default:  o = '0;
        endcase
        return o;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got %05h, expected %05h", name, idx, act, exp);
        end
    endtask

    task automatic cycle(input bit r, input logic [5:0] op, input bit mr);
        @(negedge clk);
        rst       = r;
        op_code   = op;
        mem_ready = mr;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        logic [5:0]  op;
        bit          mr;
        int          st;
        logic [19:0] out;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input logic [5:0] op, input bit mr, input int st,
                       input bit bne, input logic [1:0] fc);
        vec_t v;
        v.rst = r; v.op = op; v.mr = mr; v.st = st;
        v.out = exp_out(st, mr, bne, fc);
        vecs.push_back(v);
    endtask

    // ---------------- reference model ----------------
    // Tracks the instruction as a queue of remaining states; waiting states
    // stall the queue until mem_ready or the timeout budget is exhausted.
    int         m_state;
    int         m_route[$];
    int         m_wait;
    logic [1:0] m_code;
    bit         m_bne;

    task automatic model_step(input bit r, input logic [5:0] op, input bit mr);
        int nxt;
        if (r) begin
            m_state = S_IDLE; m_route.delete(); m_wait = 0; m_code = 2'b00; m_bne = 1'b0;
            return;
        end
        if (m_state == S_FAULT) return;
        if ((m_state == S_FETCH || m_state == S_MEMRD || m_state == S_MEMWR) && !mr) begin
            if (TMO > 0 && m_wait == TMO - 1) begin
                m_state = S_FAULT;
                m_code  = 2'b10;
            end else begin
                m_wait++;
            end
            return;
        end
        if (m_state == S_FETCH) begin
            nxt = S_DECODE;
        end else if (m_state == S_DECODE) begin
            m_route.delete();
            m_bne = 1'b0;
            case (op)
                OP_LW:   m_route = '{S_MEMADR, S_MEMRD, S_MEMWB};
                OP_SW:   m_route = '{S_MEMADR, S_MEMWR};
                OP_R:    m_route = '{S_RTEXE, S_ALUWB};
                OP_ADDI: m_route = '{S_ADDIEX, S_ADDIWB};
                OP_BEQ:  m_route = '{S_BRANCH};
                OP_J:    m_route = '{S_JUMP};
`ifdef MC_BNE_EN
                OP_BNE:  begin m_route = '{S_BRANCH}; m_bne = 1'b1; end
`endif
                default: m_route.delete();
            endcase
            if (m_route.size() == 0) begin
                m_state = S_FAULT;
                m_code  = 2'b01;
                return;
            end
            nxt = m_route.pop_front();
        end else begin
            nxt = (m_route.size() != 0) ? m_route.pop_front() : S_FETCH;
        end
        m_wait  = 0;
        m_state = nxt;
    endtask

    logic [5:0] ops [8] = '{OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW, OP_ILL};

    initial begin
        rst = 1'b1; op_code = '0; mem_ready = 1'b0;

        // reset, then lw with mem_ready tied high: 1,2,3,4,5,1
        add(1, OP_LW, 1, S_IDLE, 0, 0);
        add(1, OP_LW, 1, S_IDLE, 0, 0);
        add(0, OP_LW, 1, S_FETCH, 0, 0);
        add(0, OP_LW, 1, S_DECODE, 0, 0);
        add(0, OP_LW, 1, S_MEMADR, 0, 0);
        add(0, OP_LW, 1, S_MEMRD, 0, 0);
        add(0, OP_LW, 1, S_MEMWB, 0, 0);
        add(0, OP_LW, 1, S_FETCH, 0, 0);
        // reset held two cycles in the middle of MEMRD
        add(0, OP_LW, 1, S_DECODE, 0, 0);
        add(0, OP_LW, 1, S_MEMADR, 0, 0);
        add(0, OP_LW, 0, S_MEMRD, 0, 0);
        add(0, OP_LW, 0, S_MEMRD, 0, 0);
        add(1, OP_LW, 0, S_IDLE, 0, 0);
        add(1, OP_LW, 0, S_IDLE, 0, 0);
        add(0, OP_SW, 0, S_FETCH, 0, 0);
        // sw, MEMWR waits 3 cycles then completes on the last allowed cycle
        add(0, OP_SW, 1, S_DECODE, 0, 0);
        add(0, OP_SW, 1, S_MEMADR, 0, 0);
        add(0, OP_SW, 0, S_MEMWR, 0, 0);
        add(0, OP_SW, 0, S_MEMWR, 0, 0);
        add(0, OP_SW, 0, S_MEMWR, 0, 0);
        add(0, OP_SW, 0, S_MEMWR, 0, 0);
        add(0, OP_SW, 1, S_FETCH, 0, 0);
        // FETCH starved of mem_ready: fault after 4 FETCH cycles, sticky
        add(0, OP_SW, 0, S_FETCH, 0, 0);
        add(0, OP_SW, 0, S_FETCH, 0, 0);
        add(0, OP_SW, 0, S_FETCH, 0, 0);
        add(0, OP_SW, 0, S_FAULT, 0, 2'b10);
        add(0, OP_SW, 1, S_FAULT, 0, 2'b10);
        add(0, OP_J,  0, S_FAULT, 0, 2'b10);
        // illegal opcode
        add(1, OP_ILL, 1, S_IDLE, 0, 0);
        add(0, OP_ILL, 1, S_FETCH, 0, 0);
        add(0, OP_ILL, 1, S_DECODE, 0, 0);
        add(0, OP_ILL, 1, S_FAULT, 0, 2'b01);
        add(0, OP_ILL, 1, S_FAULT, 0, 2'b01);
        add(0, OP_LW,  1, S_FAULT, 0, 2'b01);
        add(1, OP_LW,  1, S_IDLE, 0, 0);
        // beq, j, R-type, addi back to back
        add(0, OP_BEQ, 1, S_FETCH, 0, 0);
        add(0, OP_BEQ, 1, S_DECODE, 0, 0);
        add(0, OP_BEQ, 1, S_BRANCH, 0, 0);
        add(0, OP_J,   1, S_FETCH, 0, 0);
        add(0, OP_J,   1, S_DECODE, 0, 0);
        add(0, OP_J,   1, S_JUMP, 0, 0);
        add(0, OP_R,   1, S_FETCH, 0, 0);
        add(0, OP_R,   1, S_DECODE, 0, 0);
        add(0, OP_R,   1, S_RTEXE, 0, 0);
        add(0, OP_R,   1, S_ALUWB, 0, 0);
        add(0, OP_ADDI, 1, S_FETCH, 0, 0);
        add(0, OP_ADDI, 1, S_DECODE, 0, 0);
        add(0, OP_ADDI, 1, S_ADDIEX, 0, 0);
        add(0, OP_ADDI, 1, S_ADDIWB, 0, 0);
        add(0, OP_BNE, 1, S_FETCH, 0, 0);
        add(0, OP_BNE, 1, S_DECODE, 0, 0);
`ifdef MC_BNE_EN
        add(0, OP_BNE, 1, S_BRANCH, 1, 0);
        add(0, OP_BNE, 1, S_FETCH, 0, 0);
`else
        add(0, OP_BNE, 1, S_FAULT, 0, 2'b01);
        add(0, OP_BNE, 1, S_FAULT, 0, 2'b01);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].op, vecs[i].mr);
            check("directed state", i, 32'(state), 32'(vecs[i].st));
            check("directed outputs", i, 32'(act_out), 32'(vecs[i].out));
        end

        // ---------------- randomized run against the model ----------------
        begin
            int  fault_age;
            int  mr_pct;
            bit  r;
            bit  mr;
            logic [5:0] op;
            cycle(1, OP_LW, 1);
            model_step(1, OP_LW, 1);
            fault_age = 0;
            mr_pct    = 75;
            for (int i = 0; i < 3000; i++) begin
                if (i % 200 == 0) mr_pct = (mr_pct == 75) ? 35 : 75;
                r  = ($urandom_range(0, 149) == 0) || (fault_age > 4);
                mr = ($urandom_range(0, 99) < mr_pct);
                if ($urandom_range(0, 19) < 18) op = ops[$urandom_range(0, 7)];
                else op = 6'($urandom_range(0, 63));
                if (op == OP_ILL && $urandom_range(0, 3) != 0) op = OP_LW;
                cycle(r, op, mr);
                model_step(r, op, mr);
                fault_age = (m_state == S_FAULT) ? fault_age + 1 : 0;
                check("random state", i, 32'(state), 32'(m_state));
                check("random outputs", i, 32'(act_out), 32'(exp_out(m_state, mr, m_bne, m_code)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
